// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader.
// Holds the frame protocol byte values and the state encodings
// used by the frame FSM and the receive core.
package uart_boot_loader_pkg;

  // Frame protocol bytes
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  // Frame-level FSM
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_REPLY,
    ST_ERR
  } frame_state_e;

  // Receive core FSM
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_boot_loader_rx.sv
// UART 8N1 receive core for the boot loader.
// Ports:
//   clk_i      - system clock
//   rst_ni     - asynchronous active-low reset
//   rx_i       - raw serial line, idle high
//   rx_valid_o - one-cycle pulse, rx_byte_o holds a good byte
//   rx_byte_o  - last received byte (LSB first on the line)
//   rx_ferr_o  - one-cycle pulse when the stop bit was sampled low
module uart_rx_core
  import uart_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_ferr_o
);

  localparam int            CW        = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync_q;
  logic          prev_q;
  logic          rxSync;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  assign rxSync = sync_q[1];

  // Two-flop synchronizer plus one extra flop so a genuine falling edge
  // (high then low) can be told apart from a line that is simply held low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= rxSync;
    end
  end

  // Bit timer and deserializer. The start bit is re-checked half a bit in
  // so short low glitches are dropped; every later sample is one full bit
  // after the previous one, which lands in the middle of each bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (prev_q && !rxSync) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          state_d  = rxSync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d    = '0;
          shift_d  = {rxSync, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 1'b1;
          if (bitIdx_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = rxSync;
          ferr_d  = !rxSync;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Receive state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  assign rx_valid_o = valid_q;
  assign rx_byte_o  = shift_q;
  assign rx_ferr_o  = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a program image frame on i_Rx and writes it
// word by word into instruction memory, then answers ACK/NAK on o_Tx.
// Frame: A5 | count_lo | count_hi | count*4 data bytes (LE words) | xor.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   i_Rx / o_Tx         - serial lines, idle high
//   im_we/im_addr/im_wdata - instruction memory write port (1-cycle strobe)
//   cpu_hold            - high from sync byte until the reply stop bit ends
//   done / error        - sticky result of the last frame
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter int          TIMEOUT_CLKS = 1_000_000,
  parameter int          MAX_WORDS    = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_Rx,
  output logic        o_Tx,
  output logic        im_we,
  output logic [15:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int            BW           = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [BW-1:0] BIT_LAST     = BW'(CLKS_PER_BIT - 1);
  localparam int            TW           = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [15:0]   MAX_COUNT    = 16'(MAX_WORDS);

  logic       rxValid;
  logic [7:0] rxByte;
  logic       rxFerr;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .rx_i      (i_Rx),
    .rx_valid_o(rxValid),
    .rx_byte_o (rxByte),
    .rx_ferr_o (rxFerr)
  );

  frame_state_e  state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   wordIdx_q, wordIdx_d;
  logic [1:0]    byteIdx_q, byteIdx_d;
  logic [31:0]   word_q, word_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          we_q, we_d;
  logic [15:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [9:0]    txShift_q, txShift_d;
  logic [BW-1:0] txCnt_q, txCnt_d;
  logic [3:0]    txBit_q, txBit_d;
  logic          startReply;
  logic [7:0]    replyByte;
  logic [31:0]   wordNext;

  // Bytes arrive least significant first, so shifting each new byte in at
  // the top leaves byte i in bits [8i+7:8i] once all four are in.
  assign wordNext = {rxByte, word_q[31:8]};

  // Frame FSM next-state logic, including the reply shifter which only
  // runs while in REPLY. A byte in the same cycle as a timeout wins
  // because rxValid is tested first and clears the idle counter.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wordIdx_d  = wordIdx_q;
    byteIdx_d  = byteIdx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    idle_d     = idle_q;
    done_d     = done_q;
    error_d    = error_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    txShift_d  = txShift_q;
    txCnt_d    = txCnt_q;
    txBit_d    = txBit_q;
    startReply = 1'b0;
    replyByte  = NAK_BYTE;
    unique case (state_q)
      ST_IDLE: begin
        idle_d = '0;
        if (rxValid && rxByte == SYNC_BYTE) begin
          state_d   = ST_LEN_LO;
          done_d    = 1'b0;
          error_d   = 1'b0;
          csum_d    = '0;
          wordIdx_d = '0;
          byteIdx_d = '0;
          count_d   = '0;
        end
      end
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK: begin
        idle_d = idle_q + 1'b1;
        if (rxValid) begin
          idle_d = '0;
          case (state_q)
            ST_LEN_LO: begin
              count_d[7:0] = rxByte;
              state_d      = ST_LEN_HI;
            end
            ST_LEN_HI: begin
              count_d[15:8] = rxByte;
              if ({rxByte, count_q[7:0]} > MAX_COUNT) state_d = ST_ERR;
              else if ({rxByte, count_q[7:0]} == 16'd0) state_d = ST_CHECK;
              else state_d = ST_DATA;
            end
            ST_DATA: begin
              csum_d    = csum_q ^ rxByte;
              word_d    = wordNext;
              byteIdx_d = byteIdx_q + 1'b1;
              if (byteIdx_q == 2'd3) begin
                we_d      = 1'b1;
                addr_d    = BASE_ADDR + {wordIdx_q[13:0], 2'b00};
                wdata_d   = wordNext;
                wordIdx_d = wordIdx_q + 16'd1;
                if (wordIdx_q + 16'd1 == count_q) state_d = ST_CHECK;
              end
            end
            ST_CHECK: begin
              startReply = 1'b1;
              state_d    = ST_REPLY;
              if (rxByte == csum_q) begin
                replyByte = ACK_BYTE;
                done_d    = 1'b1;
              end else begin
                error_d = 1'b1;
              end
            end
            default: ;
          endcase
        end else if (rxFerr || idle_q == TIMEOUT_LAST) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        startReply = 1'b1;
        error_d    = 1'b1;
        state_d    = ST_REPLY;
      end
      ST_REPLY: begin
        if (txCnt_q == BIT_LAST) begin
          txCnt_d   = '0;
          txShift_d = {1'b1, txShift_q[9:1]};
          txBit_d   = txBit_q + 1'b1;
          if (txBit_q == 4'd9) state_d = ST_IDLE;
        end else begin
          txCnt_d = txCnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Load stop, data and start bits; bit 0 goes out first.
    if (startReply) begin
      txShift_d = {1'b1, replyByte, 1'b0};
      txCnt_d   = '0;
      txBit_d   = '0;
    end
  end

  // Frame FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      wordIdx_q <= '0;
      byteIdx_q <= '0;
      word_q    <= '0;
      csum_q    <= '0;
      idle_q    <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      txShift_q <= 10'h3FF;
      txCnt_q   <= '0;
      txBit_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wordIdx_q <= wordIdx_d;
      byteIdx_q <= byteIdx_d;
      word_q    <= word_d;
      csum_q    <= csum_d;
      idle_q    <= idle_d;
      done_q    <= done_d;
      error_q   <= error_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      txShift_q <= txShift_d;
      txCnt_q   <= txCnt_d;
      txBit_q   <= txBit_d;
    end
  end

  assign o_Tx     = (state_q == ST_REPLY) ? txShift_q[0] : 1'b1;
  assign cpu_hold = (state_q != ST_IDLE);
  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for the UART boot loader. Frames are built from word
// lists; the expected memory writes and reply byte are pushed into queues
// and popped by independent write and serial-TX monitors.
module tb_uart_boot_loader;

  localparam int          CPB  = 16;
  localparam int          TO   = 2000;
  localparam int          MAXW = 16384;
  localparam logic [15:0] BASE = 16'h0000;

  typedef logic [7:0]  byteQ_t[$];
  typedef logic [31:0] wordQ_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rxLine;
  logic        oTx, imWe, cpuHold, doneO, errorO;
  logic [15:0] imAddr;
  logic [31:0] imWdata;

  int total = 0;
  int bad = 0;
  int txExpected = 0;
  int txSeen = 0;

  logic [15:0] expAddrQ[$];
  logic [31:0] expDataQ[$];
  logic [7:0]  expTxQ[$];

  always #5 clk = ~clk;

  uart_boot_loader #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR   (BASE),
    .TIMEOUT_CLKS(TO),
    .MAX_WORDS   (MAXW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_Rx    (rxLine),
    .o_Tx    (oTx),
    .im_we   (imWe),
    .im_addr (imAddr),
    .im_wdata(imWdata),
    .cpu_hold(cpuHold),
    .done    (doneO),
    .error   (errorO)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one 8N1 byte; stopBit=0 forces a framing error.
  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    rxLine = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxLine = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxLine = stopBit;
    repeat (CPB) @(negedge clk);
    rxLine = 1'b1;
  endtask

  task automatic applyStimulus(input byteQ_t bytes);
    foreach (bytes[i]) begin
      sendByte(bytes[i], 1'b1);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
  endtask

  // Bounded wait for the loader to release the CPU, then confirm the reply
  // byte had fully gone out by then.
  task automatic waitIdle(input string name, input int limit);
    int n = 0;
    while (cpuHold !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " hold released"}, 32'(cpuHold), 32'd0);
    checkOutput({name, " reply complete"}, 32'(txSeen), 32'(txExpected));
  endtask

  // Reference model: a frame of N words writes word i to BASE+4i, and the
  // reply is ACK only when the trailing byte equals the XOR of data bytes.
  task automatic loadFrame(input string name, input wordQ_t words, input bit corrupt);
    byteQ_t      frame;
    logic [7:0]  cs;
    logic [15:0] n;
    logic [31:0] w;
    logic [7:0]  b;
    cs = 8'h00;
    n  = 16'(words.size());
    frame.push_back(8'hA5);
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
    foreach (words[i]) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        frame.push_back(b);
        cs = cs ^ b;
      end
      expAddrQ.push_back(BASE + 16'(4 * i));
      expDataQ.push_back(w);
    end
    if (corrupt) cs = cs ^ 8'(1 + $urandom_range(0, 254));
    frame.push_back(cs);
    expTxQ.push_back(corrupt ? 8'h15 : 8'h06);
    txExpected++;
    applyStimulus(frame);
    waitIdle(name, 40 * CPB);
    checkOutput({name, " done"}, 32'(doneO), corrupt ? 32'd0 : 32'd1);
    checkOutput({name, " error"}, 32'(errorO), corrupt ? 32'd1 : 32'd0);
  endtask

  // Write monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (imWe === 1'b1) begin
        if (expAddrQ.size() == 0) begin
          checkOutput("unexpected write", 32'(imAddr), 32'hFFFF_FFFF);
        end else begin
          checkOutput("write addr", 32'(imAddr), 32'(expAddrQ.pop_front()));
          checkOutput("write data", imWdata, expDataQ.pop_front());
        end
      end
    end
  end

  // Serial TX monitor: decodes each reply byte mid-bit.
  initial begin
    logic [7:0] rb;
    forever begin
      @(negedge oTx);
      repeat (CPB / 2) @(posedge clk);
      #1;
      checkOutput("tx start bit", 32'(oTx), 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1;
        rb[i] = oTx;
      end
      repeat (CPB) @(posedge clk);
      #1;
      checkOutput("tx stop bit", 32'(oTx), 32'd1);
      if (expTxQ.size() == 0) checkOutput("unexpected reply", 32'(rb), 32'h100);
      else checkOutput("reply byte", 32'(rb), 32'(expTxQ.pop_front()));
      txSeen++;
    end
  end

  // Guard against a hung run
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: run did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wordQ_t ws;
    byteQ_t bs;
    rst_n  = 1'b0;
    rxLine = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset im_we", 32'(imWe), 32'd0);
    checkOutput("reset im_addr", 32'(imAddr), 32'd0);
    checkOutput("reset im_wdata", imWdata, 32'd0);
    checkOutput("reset cpu_hold", 32'(cpuHold), 32'd0);
    checkOutput("reset done", 32'(doneO), 32'd0);
    checkOutput("reset error", 32'(errorO), 32'd0);
    checkOutput("reset o_Tx", 32'(oTx), 32'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] good load");
    ws = {32'h1234_5678, 32'hDEAD_BEEF};
    loadFrame("good", ws, 1'b0);

    $display("[TB] bad checksum");
    loadFrame("badsum", ws, 1'b1);

    $display("[TB] noise before sync");
    sendByte(8'h00, 1'b1);
    sendByte(8'hFF, 1'b1);
    sendByte(8'h3C, 1'b1);
    repeat (30) @(negedge clk);
    checkOutput("noise no hold", 32'(cpuHold), 32'd0);
    ws = {};
    loadFrame("empty", ws, 1'b0);

    $display("[TB] oversize count");
    expTxQ.push_back(8'h15);
    txExpected++;
    bs = {8'hA5, 8'h01, 8'h40};
    applyStimulus(bs);
    waitIdle("oversize", 40 * CPB);
    checkOutput("oversize error", 32'(errorO), 32'd1);
    checkOutput("oversize done", 32'(doneO), 32'd0);

    $display("[TB] timeout");
    expTxQ.push_back(8'h15);
    txExpected++;
    bs = {8'hA5, 8'h01, 8'h00, 8'h12, 8'h34};
    applyStimulus(bs);
    repeat (TO / 2) @(negedge clk);
    checkOutput("timeout still holding", 32'(cpuHold), 32'd1);
    waitIdle("timeout", TO + 40 * CPB);
    checkOutput("timeout error", 32'(errorO), 32'd1);

    $display("[TB] framing error");
    expTxQ.push_back(8'h15);
    txExpected++;
    bs = {8'hA5, 8'h01, 8'h00, 8'h11};
    applyStimulus(bs);
    sendByte(8'h22, 1'b0);
    waitIdle("ferr", 40 * CPB);
    checkOutput("ferr error", 32'(errorO), 32'd1);
    checkOutput("ferr done", 32'(doneO), 32'd0);

    $display("[TB] idle glitch");
    rxLine = 1'b0;
    repeat (5) @(negedge clk);
    rxLine = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    checkOutput("glitch no hold", 32'(cpuHold), 32'd0);
    checkOutput("glitch no reply", 32'(txSeen), 32'(txExpected));

    $display("[TB] reset mid-data");
    expAddrQ.push_back(BASE);
    expDataQ.push_back(32'hCAFE_F00D);
    bs = {8'hA5, 8'h02, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h11, 8'h22};
    applyStimulus(bs);
    checkOutput("pre-reset write seen", 32'(expAddrQ.size()), 32'd0);
    checkOutput("pre-reset holding", 32'(cpuHold), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset cpu_hold", 32'(cpuHold), 32'd0);
    checkOutput("async reset im_we", 32'(imWe), 32'd0);
    checkOutput("async reset im_addr", 32'(imAddr), 32'd0);
    checkOutput("async reset im_wdata", imWdata, 32'd0);
    checkOutput("async reset o_Tx", 32'(oTx), 32'd1);
    checkOutput("async reset error", 32'(errorO), 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    ws = {32'h0BAD_F00D, 32'h1357_9BDF, 32'h0000_0009};
    loadFrame("after reset", ws, 1'b0);

    $display("[TB] random frames");
    for (int f = 0; f < 4; f++) begin
      int nw;
      nw = $urandom_range(1, 4);
      ws = {};
      for (int i = 0; i < nw; i++) ws.push_back($urandom);
      loadFrame("random", ws, ($urandom_range(0, 3) == 0));
    end

    repeat (4 * CPB) @(negedge clk);
    checkOutput("writes left over", 32'(expAddrQ.size()), 32'd0);
    checkOutput("replies left over", 32'(expTxQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
